// File: rtl/spi_adc_scan.sv
// Round-robin SPI ADC scanner: shifts a channel address out on dout, captures the
// conversion result from din, and presents it with its channel tag and a ready pulse.
module spi_adc_scan #(
  parameter int ADC_WIDTH    = 12,
  parameter int NUM_CHANNELS = 8,
  parameter int CHAN_WIDTH   = 3,
  parameter int CLK_DIV      = 20,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    en,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  input  logic                    din,
  output logic                    sclk,
  output logic                    cs_n,
  output logic                    dout,
  output logic [ADC_WIDTH-1:0]    vd,
  output logic [CHAN_WIDTH-1:0]   vd_chan,
  output logic                    vd_rdy,
  output logic                    scan_done,
  output logic                    busy
);

  localparam int FRAME_LEN = CHAN_WIDTH + ADC_WIDTH;
  localparam int HALF      = CLK_DIV / 2;
  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int BIT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_RISE  = DIV_W'(HALF - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_DATA0 = BIT_W'(CHAN_WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]              state;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [CHAN_WIDTH-1:0]   chan;
  logic [NUM_CHANNELS-1:0] frame_mask;
  logic [CHAN_WIDTH-1:0]   addr_sh;
  logic [ADC_WIDTH-1:0]    shreg;

  logic [CHAN_WIDTH-1:0]   first_chan;
  logic [CHAN_WIDTH-1:0]   above_chan;
  logic                    above_found;
  logic [CHAN_WIDTH-1:0]   top_chan;
  logic [CHAN_WIDTH-1:0]   sel_chan;
  logic                    start_frame;

  // Channel selection uses the live mask; end-of-sweep detection uses the mask latched at frame start.
  always_comb begin
    first_chan  = '0;
    above_chan  = '0;
    above_found = 1'b0;
    top_chan    = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        first_chan = CHAN_WIDTH'(i);
        if (i > int'(chan)) begin
          above_chan  = CHAN_WIDTH'(i);
          above_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (frame_mask[i]) top_chan = CHAN_WIDTH'(i);
    end
    sel_chan    = (state == GAP && above_found) ? above_chan : first_chan;
    start_frame = en && (|chan_mask) &&
                  ((state == IDLE) || (state == GAP && gap_cnt == GAP_LAST));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      chan       <= '0;
      frame_mask <= '0;
      addr_sh    <= '0;
      shreg      <= '0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      dout       <= 1'b0;
      vd         <= '0;
      vd_chan    <= '0;
      vd_rdy     <= 1'b0;
      scan_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vd_rdy    <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        IDLE: ;
        SHIFT: begin
          if (div_cnt == DIV_RISE) begin
            sclk <= 1'b1;
            if (bit_cnt >= BIT_DATA0) shreg <= {shreg[ADC_WIDTH-2:0], din};
          end
          if (div_cnt == DIV_LAST) begin
            sclk    <= 1'b0;
            div_cnt <= '0;
            dout    <= addr_sh[CHAN_WIDTH-1];
            addr_sh <= addr_sh << 1;
            if (bit_cnt == BIT_LAST) begin
              cs_n      <= 1'b1;
              dout      <= 1'b0;
              vd        <= shreg;
              vd_chan   <= chan;
              vd_rdy    <= 1'b1;
              scan_done <= (chan == top_chan);
              gap_cnt   <= '0;
              state     <= GAP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A frame start overrides the GAP->IDLE fall-through above.
      if (start_frame) begin
        state      <= SHIFT;
        cs_n       <= 1'b0;
        busy       <= 1'b1;
        sclk       <= 1'b0;
        chan       <= sel_chan;
        frame_mask <= chan_mask;
        dout       <= sel_chan[CHAN_WIDTH-1];
        addr_sh    <= sel_chan << 1;
        div_cnt    <= '0;
        bit_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_scan.sv
// Scoreboard bench for spi_adc_scan: directed scans against an address-aware ADC model,
// plus a second instance checking SCLK and frame timing at CLK_DIV=20.
module tb_spi_adc_scan;

  localparam int AW  = 12;
  localparam int NC  = 8;
  localparam int CW  = 3;
  localparam int DIV = 4;
  localparam int GP  = 2;

  typedef struct packed {
    logic          done;
    logic [CW-1:0] chan;
    logic [AW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          en = 1'b0;
  logic [NC-1:0] chan_mask = '0;
  logic          din = 1'b0;
  logic          sclk, cs_n, dout, vd_rdy, scan_done, busy;
  logic [AW-1:0] vd;
  logic [CW-1:0] vd_chan;

  logic          en20 = 1'b0;
  logic [NC-1:0] mask20 = '0;
  logic          din20 = 1'b1;
  logic          sclk20, cs_n20, dout20, vd_rdy20, scan_done20, busy20;
  logic [AW-1:0] vd20;
  logic [CW-1:0] vd_chan20;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [AW-1:0] adc_val [NC] = '{12'h123, 12'h3C4, 12'hA5C, 12'h456,
                                  12'h789, 12'hABC, 12'hDEF, 12'hF0E};

  int            rcnt = 0;
  int            fcnt = 0;
  int            model_idx = 0;
  logic [CW-1:0] addr_rx = '0;

  spi_adc_scan #(.ADC_WIDTH(AW), .NUM_CHANNELS(NC), .CHAN_WIDTH(CW),
                 .CLK_DIV(DIV), .GAP_CYCLES(GP)) u_dut (
    .clk(clk), .n_rst(n_rst), .en(en), .chan_mask(chan_mask), .din(din),
    .sclk(sclk), .cs_n(cs_n), .dout(dout), .vd(vd), .vd_chan(vd_chan),
    .vd_rdy(vd_rdy), .scan_done(scan_done), .busy(busy));

  spi_adc_scan #(.ADC_WIDTH(AW), .NUM_CHANNELS(NC), .CHAN_WIDTH(CW),
                 .CLK_DIV(20), .GAP_CYCLES(GP)) u_dut20 (
    .clk(clk), .n_rst(n_rst), .en(en20), .chan_mask(mask20), .din(din20),
    .sclk(sclk20), .cs_n(cs_n20), .dout(dout20), .vd(vd20), .vd_chan(vd_chan20),
    .vd_rdy(vd_rdy20), .scan_done(scan_done20), .busy(busy20));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: latches the address on SCLK rises, launches the addressed value on SCLK falls.
  always @(negedge cs_n) begin
    rcnt    = 0;
    fcnt    = 0;
    addr_rx = '0;
    din     = 1'b0;
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      if (rcnt < CW) addr_rx = {addr_rx[CW-2:0], dout};
      rcnt++;
    end
  end

  always @(negedge sclk) begin
    if (!cs_n) begin
      model_idx = AW - 1 - (fcnt + 1 - CW);
      if (fcnt + 1 >= CW && model_idx >= 0) din = adc_val[addr_rx][model_idx];
      else din = 1'b0;
      fcnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [NC-1:0] m);
    en        = e;
    chan_mask = m;
  endtask

  task automatic push_exp(input int ch, input logic done);
    exp_t e;
    e.done = done;
    e.chan = CW'(ch);
    e.data = adc_val[ch];
    exp_q.push_back(e);
  endtask

  task automatic wait_cond(input int sel, input logic val, input int budget, input string name);
    logic s;
    int   n;
    s = ~val;
    n = 0;
    while (s !== val && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      case (sel)
        0: s = cs_n;
        1: s = sclk;
        2: s = vd_rdy;
        3: s = busy;
        4: s = cs_n20;
        5: s = sclk20;
        6: s = vd_rdy20;
        7: s = busy20;
        default: s = 1'bx;
      endcase
    end
    if (s !== val) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout %s: got %b expected %b after %0d cycles", name, s, val, n);
    end
  endtask

  // Monitor: every ready pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (vd_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got chan %0d data %0h expected no result", vd_chan, vd);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_vd", 32'(vd), 32'(e.data));
        checkOutput("sb_vd_chan", 32'(vd_chan), 32'(e.chan));
        checkOutput("sb_scan_done", 32'(scan_done), 32'(e.done));
      end
    end else if (scan_done === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_lone_done: got scan_done 1 expected 0 without vd_rdy");
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, t_en, tr, tf, r, bl, csl, bh;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sclk", 32'(sclk), 0);
    checkOutput("rst_cs_n", 32'(cs_n), 1);
    checkOutput("rst_dout", 32'(dout), 0);
    checkOutput("rst_vd", 32'(vd), 0);
    checkOutput("rst_vd_chan", 32'(vd_chan), 0);
    checkOutput("rst_vd_rdy", 32'(vd_rdy), 0);
    checkOutput("rst_scan_done", 32'(scan_done), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_cs_n20", 32'(cs_n20), 1);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single channel 2: latency, sclk phase, frame length, gap.
    t_en = cyc;
    push_exp(2, 1'b1);
    applyStimulus(1'b1, 8'h04);
    wait_cond(0, 1'b0, 10, "t1_csn_fall");
    t0 = cyc;
    checkOutput("t1_start_lat", 32'(t0 - t_en), 1);
    checkOutput("t1_busy", 32'(busy), 1);
    wait_cond(1, 1'b1, 10, "t1_sclk_rise");
    checkOutput("t1_sclk_rise0", 32'(cyc - t0), 2);
    wait_cond(2, 1'b1, 100, "t1_rdy");
    checkOutput("t1_rdy_time", 32'(cyc - t0), 60);
    checkOutput("t1_cs_n_end", 32'(cs_n), 1);
    checkOutput("t1_addr_rx", 32'(addr_rx), 2);
    wait_cond(0, 1'b0, 10, "t1_next_fall");
    checkOutput("t1_next_frame", 32'(cyc - t0), 62);
    push_exp(2, 1'b1);
    applyStimulus(1'b0, 8'h04);
    wait_cond(3, 1'b0, 200, "t1_idle");

    // en dropped mid-frame: frame completes, then idle.
    push_exp(2, 1'b1);
    applyStimulus(1'b1, 8'h04);
    wait_cond(0, 1'b0, 10, "t2_csn_fall");
    t0 = cyc;
    repeat (20) @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h04);
    wait_cond(2, 1'b1, 100, "t2_rdy");
    checkOutput("t2_rdy_time", 32'(cyc - t0), 60);
    wait_cond(3, 1'b0, 10, "t2_busy_low");
    checkOutput("t2_busy_time", 32'(cyc - t0), 62);
    csl = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) csl++;
    end
    checkOutput("t2_no_frames", 32'(csl), 0);

    // Sweep over mask 1000_0101.
    push_exp(0, 1'b0); push_exp(2, 1'b0); push_exp(7, 1'b1);
    push_exp(0, 1'b0); push_exp(2, 1'b0); push_exp(7, 1'b1);
    applyStimulus(1'b1, 8'h85);
    wait_cond(0, 1'b0, 10, "t3_csn_fall");
    r = 0; bl = 0;
    for (int n = 0; n < 600 && r < 6; n++) begin
      @(posedge clk);
      #1;
      if (!busy) bl++;
      if (vd_rdy) r++;
    end
    applyStimulus(1'b0, 8'h85);
    checkOutput("t3_frames", 32'(r), 6);
    checkOutput("t3_busy_low", 32'(bl), 0);
    wait_cond(3, 1'b0, 200, "t3_idle");

    // Reset in the middle of the ch2 frame.
    push_exp(0, 1'b0);
    applyStimulus(1'b1, 8'h85);
    wait_cond(2, 1'b1, 100, "t4_rdy0");
    wait_cond(0, 1'b0, 10, "t4_ch2_fall");
    repeat (22) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    checkOutput("t4_sclk", 32'(sclk), 0);
    checkOutput("t4_cs_n", 32'(cs_n), 1);
    checkOutput("t4_vd", 32'(vd), 0);
    checkOutput("t4_busy", 32'(busy), 0);
    checkOutput("t4_vd_rdy", 32'(vd_rdy), 0);
    repeat (3) @(posedge clk);
    #1;
    push_exp(0, 1'b0);
    n_rst = 1'b1;
    wait_cond(2, 1'b1, 100, "t4_rdy_after");
    applyStimulus(1'b0, 8'h85);
    wait_cond(3, 1'b0, 200, "t4_idle");

    // Empty mask holds idle; mask change mid-frame applies at the next selection.
    applyStimulus(1'b1, 8'h00);
    csl = 0; bh = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) csl++;
      if (busy) bh++;
    end
    checkOutput("t5_csn_low", 32'(csl), 0);
    checkOutput("t5_busy_high", 32'(bh), 0);
    push_exp(0, 1'b0);
    push_exp(0, 1'b1);
    applyStimulus(1'b1, 8'h03);
    wait_cond(0, 1'b0, 10, "t5_csn_fall");
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h01);
    wait_cond(2, 1'b1, 100, "t5_rdy0");
    wait_cond(2, 1'b1, 100, "t5_rdy1");
    applyStimulus(1'b0, 8'h01);
    wait_cond(3, 1'b0, 200, "t5_idle");

    // CLK_DIV=20 instance: 10/10 SCLK duty, 300-cycle chip select.
    en20   = 1'b1;
    mask20 = 8'h01;
    wait_cond(4, 1'b0, 10, "t6_csn_fall");
    t0 = cyc;
    wait_cond(5, 1'b1, 30, "t6_rise0");
    tr = cyc;
    checkOutput("t6_first_rise", 32'(tr - t0), 10);
    wait_cond(5, 1'b0, 30, "t6_fall0");
    tf = cyc;
    checkOutput("t6_sclk_high", 32'(tf - tr), 10);
    wait_cond(5, 1'b1, 30, "t6_rise1");
    checkOutput("t6_sclk_low", 32'(cyc - tf), 10);
    wait_cond(6, 1'b1, 400, "t6_rdy");
    en20 = 1'b0;
    checkOutput("t6_csn_low_len", 32'(cyc - t0), 300);
    checkOutput("t6_cs_n_end", 32'(cs_n20), 1);
    checkOutput("t6_vd", 32'(vd20), 32'hFFF);
    checkOutput("t6_vd_chan", 32'(vd_chan20), 0);
    checkOutput("t6_scan_done", 32'(scan_done20), 1);
    wait_cond(7, 1'b0, 20, "t6_idle");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
